// File: rtl/dm_host_ctl.sv
// dm_host_ctl: loads operands into data memory, runs the core until done, then dumps a result window.
// Optional run watchdog enabled by defining DM_HOST_TIMEOUT_EN.
module dm_host_ctl #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] ld_base,
    input  logic [7:0]    ld_cnt,
    input  logic [AW-1:0] rd_base,
    input  logic [7:0]    rd_cnt,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          dm_we,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_di,
    input  logic [DW-1:0] dm_dout,
    output logic          cpu_rst,
    input  logic          cpu_done,
    output logic          busy,
    output logic          fin,
    output logic          err
);
    typedef enum logic [2:0] {IDLE, LOAD, RUN, DUMP, FIN} state_t;
    state_t        st;
    logic [AW-1:0] lb, rb;
    logic [7:0]    lc, rc, idx;
    logic          done_q;
`ifdef DM_HOST_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);
    logic [15:0] wd;
    logic        err_q;
    logic        expire;
    assign expire = st == RUN && !done_q && wd == WD_LAST;
    assign err    = err_q;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            wd    <= '0;
            err_q <= 1'b0;
        end else begin
            wd    <= st == RUN ? wd + 16'd1 : 16'd0;
            err_q <= (st == IDLE && start) ? 1'b0 : (err_q | expire);
        end
`else
    logic expire;
    assign expire = 1'b0;
    assign err    = 1'b0;
`endif
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            st     <= IDLE;
            idx    <= '0;
            lb     <= '0;
            rb     <= '0;
            lc     <= '0;
            rc     <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= st == RUN && cpu_done;
            case (st)
                IDLE: if (start) begin
                    lb  <= ld_base;
                    lc  <= ld_cnt;
                    rb  <= rd_base;
                    rc  <= rd_cnt;
                    idx <= '0;
                    st  <= ld_cnt != 8'd0 ? LOAD : RUN;
                end
                LOAD: if (in_valid) begin
                    idx <= idx == lc - 8'd1 ? 8'd0 : idx + 8'd1;
                    if (idx == lc - 8'd1) st <= RUN;
                end
                RUN: if (done_q) st <= rc != 8'd0 ? DUMP : FIN;
                     else if (expire) st <= FIN;
                DUMP: if (out_ready) begin
                    idx <= idx == rc - 8'd1 ? 8'd0 : idx + 8'd1;
                    if (idx == rc - 8'd1) st <= FIN;
                end
                default: st <= IDLE;
            endcase
        end
    // Outputs decode the registered state, so reset forces them immediately.
    always_comb begin
        busy      = st != IDLE;
        cpu_rst   = st != RUN;
        fin       = st == FIN;
        in_ready  = st == LOAD;
        out_valid = st == DUMP;
        dm_we     = in_ready && in_valid;
        dm_addr   = in_ready ? lb + AW'(idx) : out_valid ? rb + AW'(idx) : '0;
        dm_di     = in_ready ? in_data : '0;
        out_data  = out_valid ? dm_dout : '0;
    end
endmodule

// File: tb/tb_dm_host_ctl.sv
// tb_dm_host_ctl: randomized load/run/dump transactions against a memory-image reference model.
module tb_dm_host_ctl;
    logic       clk = 0, reset = 0, start = 0, in_valid = 0, out_ready = 0, cpu_done = 0;
    logic [7:0] ld_base = 0, ld_cnt = 0, rd_base = 0, rd_cnt = 0, in_data = 0;
    logic       in_ready, out_valid, dm_we, cpu_rst, busy, fin, err;
    logic [7:0] out_data, dm_addr, dm_di, dm_dout;
    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic [15:0] wq [$];
    logic [7:0]  dq [$];
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    dm_host_ctl #(.AW(8), .DW(8), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .start(start),
        .ld_base(ld_base), .ld_cnt(ld_cnt), .rd_base(rd_base), .rd_cnt(rd_cnt),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_di(dm_di), .dm_dout(dm_dout),
        .cpu_rst(cpu_rst), .cpu_done(cpu_done), .busy(busy), .fin(fin), .err(err)
    );

    assign dm_dout = mem[dm_addr];
    always @(posedge clk) if (dm_we) mem[dm_addr] <= dm_di;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_vec(input string tag);
        check(tag, {cpu_rst, busy, err, fin, in_ready, out_valid, dm_we, dm_addr, dm_di, out_data},
              {1'b1, 30'b0});
    endtask

    // Every committed write and every dump handshake is matched against the model queues.
    always @(negedge clk) if (reset) begin
        if (dm_we) begin
            if (wq.size() == 0) check("spur_we", dm_we, 0);
            else check("wr", {dm_addr, dm_di}, wq.pop_front());
        end
        if (out_valid && dq.size() == 0) check("spur_ov", out_valid, 0);
        else if (out_valid && out_ready) check("rd", out_data, dq.pop_front());
    end

    task automatic run_txn(input logic [7:0] lb, input logic [7:0] lc, input logic [7:0] rb,
                           input logic [7:0] rc, input bit gap, input int bp, input bit fixed,
                           input int dly, input bit poke);
        logic [7:0] dat [256];
        logic [7:0] a, pa, pd;
        int i, c, j;
        bit acc, pv;
        for (int k = 0; k < lc; k++) begin
            dat[k] = fixed ? 8'hA1 + 8'(k) : 8'($urandom);
            a = lb + 8'(k);
            ref_mem[a] = dat[k];
            wq.push_back({a, dat[k]});
        end
        for (int k = 0; k < rc; k++) dq.push_back(ref_mem[8'(rb + 8'(k))]);
        start = 1; ld_base = lb; ld_cnt = lc; rd_base = rb; rd_cnt = rc;
        tick();
        start = 0;
        ld_base = 8'($urandom); ld_cnt = 8'($urandom); rd_base = 8'($urandom); rd_cnt = 8'($urandom);
        check("busy", busy, 1);
        check("err_clr", err, 0);
        check("entry", {in_ready, cpu_rst}, lc != 0 ? 2'b11 : 2'b00);
        i = 0; c = 0;
        while (i < lc && c < 2000) begin
            in_valid = gap ? $urandom_range(0, 2) != 0 : 1'b1;
            in_data  = in_valid ? dat[i] : 8'($urandom);
            cpu_done = 1'($urandom_range(0, 1));
            acc = in_valid && in_ready;
            tick();
            if (acc) i++;
            c++;
        end
        in_valid = 0; cpu_done = 0;
        check("ld_done", i, lc);
        if (lc != 0 && !gap) check("ld_cyc", c, lc);
        check("run_rst", cpu_rst, 0);
        repeat (dly) begin
            if (poke) begin
                start = 1; ld_base = 8'($urandom); ld_cnt = 8'($urandom_range(1, 9));
                rd_base = 8'($urandom); rd_cnt = 8'($urandom_range(1, 9));
            end
            tick();
            start = 0;
        end
        check("run_hold", {cpu_rst, out_valid, busy}, 3'b001);
        cpu_done = 1;
        tick();
        cpu_done = 0;
        check("done_m1", cpu_rst, 0);
        tick();
        if (rc != 0) check("dump_ent", {out_valid, cpu_rst}, 2'b11);
        j = 0; c = 0; pv = 0; pa = 0; pd = 0;
        while (j < rc && c < 2000) begin
            out_ready = bp == 0 ? 1'b1 : bp == 1 ? 1'($urandom_range(0, 1)) : !(c >= 1 && c <= 5);
            cpu_done  = 1'($urandom_range(0, 1));
            if (pv) begin
                check("stall_a", dm_addr, pa);
                check("stall_d", out_data, pd);
            end
            pv = out_valid && !out_ready;
            pa = dm_addr; pd = out_data;
            if (out_valid && out_ready) j++;
            tick();
            c++;
        end
        out_ready = 0; cpu_done = 0;
        check("dmp_done", j, rc);
        if (rc != 0 && bp == 0) check("dmp_cyc", c, rc);
        check("fin", {fin, cpu_rst, out_valid}, 3'b110);
        tick();
        check("fin_end", {fin, busy}, 2'b00);
        check("q_empty", wq.size() + dq.size(), 0);
    endtask

    initial begin
        int c, stuck;
        for (int k = 0; k < 256; k++) begin
            mem[k] = 8'(k) ^ 8'h5A;
            ref_mem[k] = 8'(k) ^ 8'h5A;
        end
        #1 rst_vec("rst0");
        tick(); tick();
        rst_vec("rst1");
        reset = 1;
        tick();
        rst_vec("idle");
        run_txn(8'h10, 4, 8'h10, 4, 0, 0, 1, 3, 1);
        run_txn(8'h33, 0, 8'h44, 0, 0, 0, 0, 2, 0);
        run_txn(8'hFE, 3, 8'hFD, 5, 0, 0, 0, 1, 0);
        run_txn(8'h80, 6, 8'h7F, 8, 1, 2, 0, 4, 0);
        // Reset mid-LOAD after two of four beats.
        for (int k = 0; k < 2; k++) begin
            ref_mem[8'h40 + 8'(k)] = 8'hC0 + 8'(k);
            wq.push_back({8'h40 + 8'(k), 8'hC0 + 8'(k)});
        end
        start = 1; ld_base = 8'h40; ld_cnt = 4; rd_base = 8'h40; rd_cnt = 4;
        tick();
        start = 0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1; in_data = 8'hC0 + 8'(k);
            tick();
        end
        in_data = 8'hEE;
        check("mid_load", {in_ready, dm_addr}, {1'b1, 8'h42});
        #1 reset = 0;
        #1 rst_vec("rst_async");
        tick();
        rst_vec("rst_hold");
        in_valid = 0; reset = 1;
        tick();
        check("q_rst", wq.size(), 0);
        run_txn(8'h40, 4, 8'h3F, 6, 0, 1, 0, 2, 0);
`ifdef DM_HOST_TIMEOUT_EN
        start = 1; ld_base = 0; ld_cnt = 0; rd_base = 0; rd_cnt = 3;
        tick();
        start = 0; c = 0;
        while (!cpu_rst && c < 100) begin
            tick();
            c++;
        end
        check("wd_cyc", c, 16);
        check("wd_fin", {fin, err, out_valid}, 3'b110);
        tick();
        check("err_sticky", {err, busy}, 2'b10);
`else
        start = 1; ld_base = 0; ld_cnt = 0; rd_base = 0; rd_cnt = 3;
        tick();
        start = 0; stuck = 0;
        repeat (40) begin
            tick();
            if (cpu_rst || err || !busy || fin) stuck++;
        end
        check("no_wd", stuck, 0);
        reset = 0;
        tick();
        reset = 1;
        tick();
`endif
        for (int n = 0; n < 40; n++)
            run_txn(8'($urandom), 8'($urandom_range(0, 12)), 8'($urandom), 8'($urandom_range(0, 12)),
                    1'($urandom_range(0, 1)), $urandom_range(0, 2), 0, $urandom_range(0, 10),
                    1'($urandom_range(0, 1)));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
